// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per clock, with sign handling done on magnitudes before and after.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd_out;
    logic [CW-1:0]       r_count;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg;
    logic                r_special;

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_abs;
    logic [XLEN-1:0]     w_b_abs;
    logic                w_is_div;
    logic                w_div_zero;
    logic                w_ovf;
    logic [XLEN-1:0]     w_special_val;
    logic                w_neg;

    // Operand conditioning at accept time: magnitudes, result sign, special cases.
    always_comb begin
        w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        w_a_neg    = w_a_signed && rs1_data[XLEN-1];
        w_b_neg    = w_b_signed && rs2_data[XLEN-1];
        w_a_abs    = w_a_neg ? (-rs1_data) : rs1_data;
        w_b_abs    = w_b_neg ? (-rs2_data) : rs2_data;
        w_is_div   = op[2];
        w_div_zero = w_is_div && (rs2_data == '0);
        w_ovf      = ((op == OP_DIV) || (op == OP_REM))
                     && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_data == '1);
        if (w_div_zero) begin
            w_special_val = op[1] ? rs1_data : '1;
        end else begin
            w_special_val = op[1] ? '0 : rs1_data;
        end
        // Remainder takes the dividend's sign; everything else the xor of both.
        if (w_is_div && op[1]) begin
            w_neg = w_a_neg;
        end else begin
            w_neg = w_a_neg ^ w_b_neg;
        end
    end

    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_part;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;

    // Multiply: acc = {partial, multiplier}; add multiplicand into the top, shift right.
    // Divide:   acc = {remainder, quotient}; shift left, trial-subtract divisor.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_div_part = r_acc[2*XLEN-1:XLEN-1];
        w_div_ge   = (w_div_part >= {1'b0, r_opnd});
        w_div_diff = w_div_part[XLEN-1:0] - r_opnd;
        if (w_div_ge) begin
            w_div_next = {w_div_diff, r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_div_next = {r_acc[2*XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quot_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_result;

    always_comb begin
        w_prod_fix = r_neg ? (-r_acc) : r_acc;
        w_quot_fix = r_neg ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_rem_fix  = r_neg ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
        if (r_special) begin
            w_result = r_acc[XLEN-1:0];
        end else if (r_op[2]) begin
            w_result = r_op[1] ? w_rem_fix : w_quot_fix;
        end else if (r_op == OP_MUL) begin
            w_result = w_prod_fix[XLEN-1:0];
        end else begin
            w_result = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_rd_out  <= '0;
            r_count   <= '0;
            r_op      <= '0;
            r_rd      <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
        end else if (kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op      <= op;
                        r_rd      <= rd_addr_in;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_neg     <= w_neg;
                        r_special <= w_div_zero || w_ovf;
                        if (w_div_zero || w_ovf) begin
                            r_acc   <= {{XLEN{1'b0}}, w_special_val};
                            r_opnd  <= '0;
                            r_state <= S_FIN;
                        end else if (w_is_div) begin
                            r_acc   <= {{XLEN{1'b0}}, w_a_abs};
                            r_opnd  <= w_b_abs;
                            r_state <= S_CALC;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_b_abs};
                            r_opnd  <= w_a_abs;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc   <= r_op[2] ? w_div_next : w_mul_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(XLEN - 1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    // First FIN edge publishes the result; the second retires the op.
                    if (!r_done) begin
                        r_result <= w_result;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign rd_addr_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and
// compared whenever the unit pulses done; latency, kill and reset are checked inline.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kill       (kill),
        .op         (op),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd_addr_in (rd_addr_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_addr_out(rd_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pushed = 0;
    int          done_cnt = 0;
    logic [36:0] exp_q[$];
    logic [31:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      ub;
        int          ia;
        int          ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("result", result, e[36:5]);
                check("rd_addr_out", rd_addr_out, e[4:0]);
                last_res = e[36:5];
                $display("op done: result=%08h rd=%0d", result, rd_addr_out);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit push);
        start      = 1'b1;
        op         = o;
        rs1_data   = a;
        rs2_data   = b;
        rd_addr_in = rd;
        if (push) begin
            exp_q.push_back({exp, rd});
            n_pushed++;
        end
    endtask

    task automatic finish_op(input int lat);
        int n;
        @(negedge clk);
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        check("busy_accept", busy, 1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        check("latency", n, lat);
        check("busy_at_done", busy, 1);
        @(negedge clk);
        check("busy_clear", busy, 0);
        check("done_clear", done, 0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat);
        @(negedge clk);
        issue(o, a, b, rd, exp, 1'b1);
        finish_op(lat);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges[5];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return $urandom;
            2:       return edges[$urandom_range(0, 4)];
            default: return -32'($urandom_range(1, 20));
        endcase
    endfunction

    initial begin
        int n;
        rst        = 1'b0;
        start      = 1'b0;
        kill       = 1'b0;
        op         = '0;
        rs1_data   = '0;
        rs2_data   = '0;
        rd_addr_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rd", rd_addr_out, 0);
        rst = 1'b1;

        // Directed values
        run_op(3'd0, 32'd7, 32'd6, 5'd9, 32'd42, 33);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd2, 32'hFFFF_FFFF, 33);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'h0000_0001, 33);
        run_op(3'd4, -32'd7, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
        run_op(3'd6, -32'd7, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
        run_op(3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 33);
        run_op(3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 33);
        run_op(3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1);

        // Kill at E10, then a fresh request at E11
        @(negedge clk);
        issue(3'd4, 32'd1000, 32'd3, 5'd13, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", busy, 0);
        check("kill_done", done, 0);
        check("kill_result", result, last_res);
        issue(3'd5, 32'd1000, 32'd3, 5'd14, 32'd333, 1'b1);
        finish_op(33);

        // Reset at E15 of a MULHU
        @(negedge clk);
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_rd", rd_addr_out, 0);
        last_res = '0;

        // Start while busy must be ignored
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd5, 5'd16, 32'd15, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        issue(3'd0, 32'd9, 32'd9, 5'd17, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_start_done", done, 1);
        repeat (45) @(negedge clk);
        check("busy_start_idle", busy, 0);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(o, a, b, 5'($urandom), model(o, a, b), latency(o, a, b));
        end

        repeat (5) @(negedge clk);
        check("done_count", done_cnt, n_pushed);
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
